debug_reg_snapshot: RTL and testbench

Frame-synchronous register snapshot controller between the CPU register-file debug read port and the VGA debug screen. Once per frame it scans all debug registers through a request/grant port into a back shadow bank, then swaps banks at the next vsync rising edge, so the screen always renders one coherent snapshot and never tears mid-frame. The screen reads the front bank combinationally through its existing `regAddr`/`regData` style port.

---
 rtl/debug_screen_pkg.sv | 13 +
 rtl/debug_shadow_bank.sv | 28 ++
 rtl/debug_reg_snapshot.sv | 148 ++++++++++++++
 tb/tb_debug_reg_snapshot.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_screen_pkg.sv
// Shared constants for the debug-screen register snapshot path: default geometry and
// the snapshot controller state encoding.
package debug_screen_pkg;

  localparam int unsigned REG_NUM_DEF = 32;
  localparam int unsigned ADDR_W_DEF  = 5;
  localparam int unsigned DATA_W_DEF  = 32;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/debug_shadow_bank.sv
// One shadow bank of debug register words: a synchronous write port and a combinational
// read port. The storage is deliberately not reset; validity is tracked by the controller.
module debug_shadow_bank
  import debug_screen_pkg::*;
#(
  parameter int unsigned REG_NUM = REG_NUM_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [REG_NUM];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/debug_reg_snapshot.sv
// Frame-synchronous register snapshot: scans the register file into a back bank once per
// frame and swaps banks on a vsync rising edge so the screen never shows a torn snapshot.
module debug_reg_snapshot
  import debug_screen_pkg::*;
#(
  parameter int unsigned REG_NUM = REG_NUM_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              vsync,
  input  logic              freeze,
  output logic              rf_req,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic              rf_gnt,
  input  logic [DATA_W-1:0] rf_data,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              busy,
  output logic              overrun,
  output logic [7:0]        frame_cnt
);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              front_sel_q, front_sel_d;
  logic              front_valid_q, front_valid_d;
  logic [7:0]        frame_cnt_q, frame_cnt_d;
  logic              overrun_q, overrun_d;
  logic              vsync_q;

  logic frame_ev;
  logic scanning;
  logic last_gnt;
  logic bank_we;
  logic [DATA_W-1:0] rdata0, rdata1;

  assign frame_ev = vsync & ~vsync_q & ~freeze;
  assign scanning = (state_q == SCAN);
  assign last_gnt = scanning & rf_gnt & (cnt_q == ADDR_W'(REG_NUM - 1));
  assign bank_we  = scanning & rf_gnt;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    front_sel_d   = front_sel_q;
    front_valid_d = front_valid_q;
    frame_cnt_d   = frame_cnt_q;
    overrun_d     = 1'b0;
    case (state_q)
      IDLE: begin
        // Nothing captured yet, so the first frame event only starts a scan.
        if (frame_ev) begin
          state_d = SCAN;
          cnt_d   = '0;
        end
      end
      SCAN: begin
        if (rf_gnt) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (last_gnt) begin
          cnt_d = '0;
          if (frame_ev) begin
            // Scan completes on the event edge: swap and restart immediately.
            front_sel_d   = ~front_sel_q;
            front_valid_d = 1'b1;
            frame_cnt_d   = frame_cnt_q + 8'd1;
            state_d       = SCAN;
          end else begin
            state_d = DONE;
          end
        end else if (frame_ev) begin
          overrun_d = 1'b1;
        end
      end
      DONE: begin
        if (frame_ev) begin
          front_sel_d   = ~front_sel_q;
          front_valid_d = 1'b1;
          frame_cnt_d   = frame_cnt_q + 8'd1;
          state_d       = SCAN;
          cnt_d         = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      front_sel_q   <= 1'b0;
      front_valid_q <= 1'b0;
      frame_cnt_q   <= 8'd0;
      overrun_q     <= 1'b0;
      vsync_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      front_sel_q   <= front_sel_d;
      front_valid_q <= front_valid_d;
      frame_cnt_q   <= frame_cnt_d;
      overrun_q     <= overrun_d;
      vsync_q       <= vsync;
    end
  end

  // The back bank is whichever one is not in front.
  debug_shadow_bank #(
    .REG_NUM (REG_NUM),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W)
  ) u_bank0 (
    .clk   (clk),
    .we    (bank_we & front_sel_q),
    .waddr (cnt_q),
    .wdata (rf_data),
    .raddr (disp_addr),
    .rdata (rdata0)
  );

  debug_shadow_bank #(
    .REG_NUM (REG_NUM),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W)
  ) u_bank1 (
    .clk   (clk),
    .we    (bank_we & ~front_sel_q),
    .waddr (cnt_q),
    .wdata (rf_data),
    .raddr (disp_addr),
    .rdata (rdata1)
  );

  assign disp_data = front_valid_q ? (front_sel_q ? rdata1 : rdata0) : '0;
  assign rf_req    = scanning;
  assign rf_addr   = cnt_q;
  assign busy      = scanning;
  assign overrun   = overrun_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_debug_reg_snapshot.sv
// Directed bench for debug_reg_snapshot: a register-file model feeds the scan and a
// queue of expected front-bank words is checked after each swap.
module tb_debug_reg_snapshot;

  logic        clk;
  logic        resetn;
  logic        vsync;
  logic        freeze;
  logic        rf_req;
  logic [4:0]  rf_addr;
  logic        rf_gnt;
  logic [31:0] rf_data;
  logic [4:0]  disp_addr;
  logic [31:0] disp_data;
  logic        busy;
  logic        overrun;
  logic [7:0]  frame_cnt;

  logic [31:0] rf_mem [32];
  logic [31:0] exp_q [$];
  int          total;
  int          bad;

  assign rf_data = rf_mem[rf_addr];

  debug_reg_snapshot #(
    .REG_NUM (32),
    .ADDR_W  (5),
    .DATA_W  (32)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .vsync     (vsync),
    .freeze    (freeze),
    .rf_req    (rf_req),
    .rf_addr   (rf_addr),
    .rf_gnt    (rf_gnt),
    .rf_data   (rf_data),
    .disp_addr (disp_addr),
    .disp_data (disp_data),
    .busy      (busy),
    .overrun   (overrun),
    .frame_cnt (frame_cnt)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  function automatic logic [31:0] pat(input int seed, input int i);
    logic [7:0] s, a;
    s = 8'(seed);
    a = 8'(i);
    if (seed == 1) return 32'(i) * 32'h0101_0101;
    return {s, a, ~a, s ^ a};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load_src(input int seed, input bit push);
    for (int i = 0; i < 32; i++) begin
      rf_mem[i] = pat(seed, i);
      if (push) exp_q.push_back(pat(seed, i));
    end
  endtask

  task automatic push_exp(input int seed);
    for (int i = 0; i < 32; i++) exp_q.push_back(pat(seed, i));
  endtask

  // All 32 reads fit inside one clock period, so no edge is crossed.
  task automatic read_all(input string tag);
    logic [31:0] e;
    for (int i = 0; i < 32; i++) begin
      disp_addr = 5'(i);
      #1;
      if (exp_q.size() == 0) begin
        check({tag, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
        e = exp_q.pop_front();
        check(tag, disp_data, e);
      end
    end
  endtask

  task automatic swap();
    rf_gnt = 1'b0;
    vsync  = 1'b1;
    cyc();
    vsync  = 1'b0;
  endtask

  initial begin
    int          n;
    int          ng;
    logic [4:0]  exp_addr;
    logic        g;

    total = 0;
    bad = 0;
    resetn = 1'b0;
    vsync = 1'b0;
    freeze = 1'b0;
    rf_gnt = 1'b0;
    disp_addr = 5'd0;
    load_src(1, 1'b0);

    // Reset values
    cyc();
    check("rst_req", 32'(rf_req), 32'd0);
    check("rst_addr", 32'(rf_addr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ovr", 32'(overrun), 32'd0);
    check("rst_fcnt", 32'(frame_cnt), 32'd0);
    check("rst_disp", disp_data, 32'd0);
    resetn = 1'b1;
    cyc();

    // First frame: scan with continuous grant, display still blank
    rf_gnt = 1'b1;
    vsync = 1'b1;
    cyc();
    vsync = 1'b0;
    check("f1_req", 32'(rf_req), 32'd1);
    check("f1_addr", 32'(rf_addr), 32'd0);
    n = 0;
    while (busy && n < 40) begin
      cyc();
      n++;
    end
    check("f1_scan_len", 32'(n), 32'd32);
    disp_addr = 5'd7;
    #1;
    check("f1_disp_blank", disp_data, 32'd0);
    check("f1_fcnt", 32'(frame_cnt), 32'd0);
    push_exp(1);

    // Second edge swaps in the pattern
    swap();
    check("f2_fcnt", 32'(frame_cnt), 32'd1);
    disp_addr = 5'd7;
    #1;
    check("f2_disp7", disp_data, 32'h0707_0707);
    read_all("f2_disp");

    // Random grant: address held while stalled, snapshot intact after swap
    load_src(2, 1'b1);
    exp_addr = 5'd0;
    ng = 0;
    for (int it = 0; it < 1000 && ng < 32; it++) begin
      g = 1'($urandom_range(0, 1));
      rf_gnt = g;
      check("rnd_req", 32'(rf_req), 32'd1);
      check("rnd_addr", 32'(rf_addr), 32'(exp_addr));
      cyc();
      if (g) begin
        ng++;
        exp_addr++;
      end
    end
    check("rnd_grants", 32'(ng), 32'd32);
    check("rnd_done", 32'(busy), 32'd0);
    swap();
    check("rnd_fcnt", 32'(frame_cnt), 32'd2);
    read_all("rnd_disp");

    // Overrun: frame event ten cycles into a scan
    load_src(3, 1'b1);
    rf_gnt = 1'b1;
    repeat (10) cyc();
    vsync = 1'b1;
    cyc();
    vsync = 1'b0;
    check("ovr_pulse", 32'(overrun), 32'd1);
    check("ovr_fcnt", 32'(frame_cnt), 32'd2);
    check("ovr_addr", 32'(rf_addr), 32'd11);
    cyc();
    check("ovr_pulse_end", 32'(overrun), 32'd0);
    repeat (19) cyc();
    check("ovr_last_addr", 32'(rf_addr), 32'd31);
    check("ovr_busy", 32'(busy), 32'd1);
    cyc();
    check("ovr_done", 32'(busy), 32'd0);
    swap();
    check("ovr_swap_fcnt", 32'(frame_cnt), 32'd3);
    read_all("ovr_disp");

    // Frame event coinciding with the last grant
    load_src(4, 1'b1);
    rf_gnt = 1'b1;
    repeat (31) cyc();
    check("coin_pre_addr", 32'(rf_addr), 32'd31);
    vsync = 1'b1;
    cyc();
    vsync = 1'b0;
    load_src(6, 1'b0);
    check("coin_fcnt", 32'(frame_cnt), 32'd4);
    check("coin_addr", 32'(rf_addr), 32'd0);
    check("coin_busy", 32'(busy), 32'd1);
    check("coin_ovr", 32'(overrun), 32'd0);
    read_all("coin_disp");

    // Freeze: scan finishes, further edges ignored
    freeze = 1'b1;
    repeat (32) cyc();
    check("frz_parked", 32'(busy), 32'd0);
    load_src(5, 1'b0);
    for (int k = 0; k < 3; k++) begin
      vsync = 1'b1;
      cyc();
      vsync = 1'b0;
      cyc();
      cyc();
      check("frz_fcnt", 32'(frame_cnt), 32'd4);
      check("frz_busy", 32'(busy), 32'd0);
    end
    push_exp(4);
    read_all("frz_disp");
    freeze = 1'b0;
    swap();
    check("unfrz_fcnt", 32'(frame_cnt), 32'd5);
    check("unfrz_busy", 32'(busy), 32'd1);
    push_exp(6);
    read_all("unfrz_disp");

    // Reset in the middle of a scan
    rf_gnt = 1'b1;
    repeat (15) cyc();
    check("mid_addr", 32'(rf_addr), 32'd15);
    resetn = 1'b0;
    #1;
    disp_addr = 5'd7;
    #1;
    check("mrst_req", 32'(rf_req), 32'd0);
    check("mrst_addr", 32'(rf_addr), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_ovr", 32'(overrun), 32'd0);
    check("mrst_fcnt", 32'(frame_cnt), 32'd0);
    check("mrst_disp", disp_data, 32'd0);
    cyc();
    resetn = 1'b1;
    cyc();
    vsync = 1'b1;
    cyc();
    vsync = 1'b0;
    check("post_busy", 32'(busy), 32'd1);
    check("post_addr", 32'(rf_addr), 32'd0);
    check("post_fcnt", 32'(frame_cnt), 32'd0);
    check("post_disp", disp_data, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
